// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding and default sizes for the multiplier sequencer
package mul_seq_pkg;
  localparam int MUL_WIDTH = 16;
  localparam int MUL_MAX_ITER = 65535;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ACCUM  = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/mul_seq_wdog.sv
// mul_seq_wdog: counts accumulate cycles and flags when the iteration limit is reached
module mul_seq_wdog
  import mul_seq_pkg::*;
#(
  parameter int MAX_ITER = MUL_MAX_ITER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tmo
);
  logic [16:0] cnt_q, cnt_d;
  assign tmo = cnt_q >= 17'(MAX_ITER);
  // clear before each accumulate phase, count while accumulating, saturate at the limit
  always_comb cnt_d = clr ? '0 : (en && !tmo) ? cnt_q + 17'd1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: valid/ready sequencer for the repeated-addition multiplier; MUL_SEQ_TIMEOUT_EN adds an accumulate watchdog
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int MAX_ITER = MUL_MAX_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] bus_out,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_p,
  output logic             clr_p,
  output logic             dec_b,
  input  logic             eqz,
  input  logic [WIDTH-1:0] prod_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d;
  logic res_err_q, res_err_d;
  logic tmo;
`ifdef MUL_SEQ_TIMEOUT_EN
  mul_seq_wdog #(.MAX_ITER(MAX_ITER)) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == LOAD_B),
    .en    (state_q == ACCUM),
    .tmo   (tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  assign res_data = res_data_q;
  assign res_err = res_err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_data_q <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_data_q <= res_data_d;
      res_err_q <= res_err_d;
    end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_data_d = res_data_q;
    res_err_d = res_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        a_d = req_a;
        b_d = req_b;
        state_d = LOAD_A;
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = ACCUM;
      ACCUM: if (eqz || tmo) begin
        res_data_d = prod_in;
        res_err_d = !eqz;
        state_d = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus_out = (state_q == LOAD_A) ? a_q : (state_q == LOAD_B) ? b_q : '0;
    ld_a = state_q == LOAD_A;
    ld_b = state_q == LOAD_B;
    clr_p = state_q == LOAD_B;
    ld_p = (state_q == ACCUM) && !eqz && !tmo;
    dec_b = ld_p;
    req_ready = state_q == IDLE;
    res_valid = state_q == DONE;
    busy = state_q != IDLE;
  end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer for the shift-free repeated-addition multiplier datapath: registers A (operand), P (product accumulator), B (down-counter), adder, and zero detect on B.
- Accepts an operand pair over a valid/ready request port and drives the shared 16-bit data bus and the ld_a/ld_b/ld_p/clr_p/dec_b strobes.
- Watches eqz, captures the product and returns it over a valid/ready result port.
- Replaces the delay-annotated controller with a fully synchronous, reset-clean FSM.

Parameters:
- WIDTH, 16, operand/product/bus width.
- MAX_ITER, 65535, accumulate-cycle limit; used only when MUL_SEQ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  operand pair offered
- req_ready  out  1  controller can accept a request
- req_a  in  WIDTH  multiplicand
- req_b  in  WIDTH  multiplier (loaded into B counter)
- bus_out  out  WIDTH  drives datapath data_in
- ld_a  out  1  load A register from bus
- ld_b  out  1  load B counter from bus
- ld_p  out  1  load P with adder output
- clr_p  out  1  clear P
- dec_b  out  1  decrement B counter
- eqz  in  1  datapath B==0 flag
- prod_in  in  WIDTH  datapath P register value
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  product (low WIDTH bits, wraps mod 2^WIDTH)
- res_err  out  1  result aborted by timeout (0 when feature is off)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release) forces IDLE. Reset values: req_ready=1, all strobes=0, bus_out=0, res_valid=0, res_data=0, res_err=0, busy=0. Reset mid-operation abandons the transaction; the datapath contents are don't-care.
- States: IDLE, LOAD_A, LOAD_B, ACCUM, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_a/req_b into internal a_q/b_q and go to LOAD_A.
- LOAD_A: bus_out=a_q, ld_a=1. Go to LOAD_B.
- LOAD_B: bus_out=b_q, ld_b=1, clr_p=1. Go to ACCUM.
- ACCUM:
  - ld_p = dec_b = !eqz; these are decoded combinationally from state and eqz.
  - When eqz=1: no strobes; register res_data<=prod_in, res_err<=0; go to DONE.
  - b=0 spends exactly one ACCUM cycle with no ld_p, giving result 0.
- DONE: res_valid=1 and res_data is held stable. On res_ready, go to IDLE; res_valid drops the next cycle.
- Outside their states, bus_out=0 and all strobes are 0. ld_a, ld_b and clr_p are never asserted together with ld_p.
- Latency, with a datapath that decrements B by 1: request accepted at cycle T, res_valid at T+4+b.
- Backpressure: there is no queue. A new request is accepted only in IDLE, one cycle after the result handshake. req_ready=0 in all other states.
- res_valid is never deasserted without a handshake. res_ready while res_valid=0 is ignored.
- Bus and strobes are glitch-free per cycle: state register plus eqz only.

Optional Feature:
- Macro: MUL_SEQ_TIMEOUT_EN.
- Defined: ACCUM cycles are counted in a 17-bit counter, cleared on entry to ACCUM. If the count reaches MAX_ITER with eqz still 0, deassert strobes, set res_data<=prod_in and res_err<=1, and go to DONE. Covers a B counter that never reaches zero.
- Undefined: no counter; ACCUM waits indefinitely for eqz; res_err is tied to 0.

Decomposition:
- Package mul_seq_pkg:
  - state enum (IDLE=0, LOAD_A=1, LOAD_B=2, ACCUM=3, DONE=4, 3-bit)
  - WIDTH default constant
  - MAX_ITER default constant
- Sub-module mul_seq_wdog holds the iteration counter and timeout compare; it is instantiated only under MUL_SEQ_TIMEOUT_EN.
- FSM, operand latches and result register stay in mul_seq_ctrl.

Test Plan:
- Bench connects the controller to a behavioural datapath model that decrements B by 1.
- a=7, b=5: res_data=35, res_err=0, res_valid at T+9; exactly 5 ld_p pulses; ld_a and ld_b 1 cycle each.
- a=1234, b=0: one ACCUM cycle, zero ld_p pulses, res_data=0 at T+4.
- a=0xFFFF, b=3: res_data=0xFFFD (wrap mod 2^16). res_ready held low 10 cycles: res_valid and res_data stable, req_ready=0, second req_valid ignored until handshake.
- Back-to-back requests (2×3, then 4×4): second accepted the cycle after returning to IDLE; results 6 then 16, in order.
- rst_n pulsed low mid-ACCUM with b=100: outputs take reset values immediately (async); the next request 3×3 returns 9.
- With MUL_SEQ_TIMEOUT_EN and MAX_ITER=8, model eqz stuck at 0: res_err=1 after 8 ld_p pulses, res_data=model P value. Without the macro, res_err stays 0 and busy stays 1.
